// File: rtl/instr_loader_encoder.sv
// rtl/instr_loader_encoder.sv - boot-time instruction encoder and loader into instruction memory
//
// Accepts compact instruction commands and encodes each one into a 32-bit
// instruction word. Each word is written to the next instruction-memory
// address, starting at 0. The core is held in reset until the command marked
// last has been written. An unencodable op or an address overflow sends the
// block to a terminal error state.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (transfer on valid & ready)
//   cmd_op            operation select (0..23 legal, 24..31 illegal)
//   cmd_rd/rn/rm      register fields
//   cmd_imm           immediate ([11:0] for data/memory ops, [23:0] for branches)
//   cmd_last          marks the final command of the program
//   mem_we/addr/wdata instruction-memory write port
//   cpu_rst           core reset, released when the load completes
//   done, err         load complete / sticky error

module instr_loader_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [3:0]        cmd_rd,
    input  logic [3:0]        cmd_rn,
    input  logic [3:0]        cmd_rm,
    input  logic [23:0]       cmd_imm,
    input  logic              cmd_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_word;
    logic              r_last;

    logic [31:0]       w_enc;
    logic              w_legal;
    logic              w_accept;
    logic              w_at_top;
    logic [11:0]       w_i12;
    logic [23:0]       w_i24;

    assign w_i12    = cmd_imm[11:0];
    assign w_i24    = cmd_imm;
    assign w_accept = (r_state == S_LOAD) && cmd_valid;
    assign w_at_top = (r_addr == {ADDR_W{1'b1}});

    // Instruction encoder; fields an op does not use simply do not appear.
    always_comb begin
        w_enc   = 32'h0;
        w_legal = 1'b1;
        case (cmd_op)
            5'd0:  w_enc = {16'hE1A0, cmd_rd, 8'h00, cmd_rm};
            5'd1:  w_enc = {16'hE3A0, cmd_rd, w_i12};
            5'd2:  w_enc = {12'hE08, cmd_rn, cmd_rd, 8'h00, cmd_rm};
            5'd3:  w_enc = {12'hE28, cmd_rn, cmd_rd, w_i12};
            5'd4:  w_enc = {12'hE04, cmd_rn, cmd_rd, 8'h00, cmd_rm};
            5'd5:  w_enc = {12'hE24, cmd_rn, cmd_rd, w_i12};
            5'd6:  w_enc = {12'hE00, cmd_rd, 4'h0, cmd_rn, 4'h9, cmd_rm};
            5'd7:  w_enc = {12'hE20, cmd_rn, cmd_rd, w_i12};
            5'd8:  w_enc = {12'hE15, cmd_rn, 4'h0, 8'h00, cmd_rm};
            5'd9:  w_enc = {12'hE35, cmd_rn, 4'h0, w_i12};
            5'd10: w_enc = {12'hE59, cmd_rn, cmd_rd, w_i12};
            5'd11: w_enc = {12'hE79, cmd_rn, cmd_rd, 8'h00, cmd_rm};
            5'd12: w_enc = {12'hE58, cmd_rn, cmd_rd, w_i12};
            5'd13: w_enc = {16'hE52D, cmd_rd, 12'h004};
            5'd14: w_enc = {16'hE49D, cmd_rd, 12'h004};
            5'd15: w_enc = {8'hEA, w_i24};
            5'd16: w_enc = {8'h0A, w_i24};
            5'd17: w_enc = {8'h1A, w_i24};
            5'd18: w_enc = {8'hCA, w_i24};
            5'd19: w_enc = {8'hBA, w_i24};
            5'd20: w_enc = {8'hAA, w_i24};
            5'd21: w_enc = {8'hDA, w_i24};
            5'd22: w_enc = {8'hEB, w_i24};
            5'd23: w_enc = 32'hE12FFF1E;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (cmd_valid) begin
                    w_next = w_legal ? S_WRITE : S_ERROR;
                end
            end
            S_WRITE: begin
                if (r_last) begin
                    w_next = S_DONE;
                end else if (w_at_top) begin
                    // Another word would not fit; stop instead of wrapping.
                    w_next = S_ERROR;
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
            r_word  <= 32'h0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && w_legal) begin
                r_word <= w_enc;
                r_last <= cmd_last;
            end
            if ((r_state == S_WRITE) && !r_last && !w_at_top) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign cmd_ready = (r_state == S_LOAD);
    assign mem_we    = (r_state == S_WRITE);
    assign mem_addr  = r_addr;
    // Word is only driven during the write so the bus reads zero when idle.
    assign mem_wdata = (r_state == S_WRITE) ? r_word : 32'h0;
    assign cpu_rst   = (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);

endmodule
